// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the mode-2 object search.
package ppu_pkg;

  localparam int          OAM_ENTRIES = 40;
  localparam int          MAX_SPRITES = 10;
  localparam logic [15:0] OAM_BASE    = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_Y  = 2'd1,
    RD_X  = 2'd2,
    FLUSH = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] oam_idx;
    logic [3:0] row;
  } sprite_entry_t;

endpackage

// File: rtl/oam_scan_match.sv
// Line-vs-object vertical range check; row is the line offset inside the object.
module oam_scan_match (
  input  logic [7:0] ly,
  input  logic [7:0] y,
  input  logic       obj_size,
  output logic       match,
  output logic [3:0] row
);

  logic [9:0] diff;
  logic [9:0] height;

  // OAM Y is offset by 16 so partially visible objects can start above line 0
  assign diff   = {2'b00, ly} + 10'd16 - {2'b00, y};
  assign height = obj_size ? 10'd16 : 10'd8;
  assign match  = !diff[9] && (diff < height);
  assign row    = diff[3:0];

endmodule

// File: rtl/oam_scan.sv
// PPU mode-2 OAM search: picks up to 10 objects covering line ly, in OAM order.
// Build option OAM_SCAN_ROW_EN keeps the per-entry row and drives it on list_row.
//
// state | meaning
// IDLE  | waiting for scan_start
// RD_Y  | read Y of entry n; capture X of entry n-1 and evaluate it
// RD_X  | read X of entry n; capture Y of entry n
// FLUSH | capture X of entry 39, evaluate it, pulse scan_done
module oam_scan
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_start,
  input  logic [7:0] ly,
  input  logic       obj_size,
  input  logic       dma_occupy_bus,
  output logic       oam_rd,
  output logic [7:0] oam_a,
  input  logic [7:0] oam_din,
  output logic       scan_busy,
  output logic       scan_done,
  output logic [3:0] sprite_count,
  input  logic [3:0] list_idx,
  output logic [7:0] list_x,
  output logic [5:0] list_oam_idx,
  output logic [3:0] list_row
);

  localparam logic [5:0] LAST_ENTRY = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] LIST_FULL  = 4'(MAX_SPRITES);

  scan_state_t   state_q, state_d;
  logic [5:0]    n_q;
  logic [5:0]    y_idx_q;
  logic [7:0]    y_q;
  logic [7:0]    ly_q;
  logic          obj_size_q;
  logic [3:0]    count_q;
  sprite_entry_t list_q [MAX_SPRITES];

  logic [7:0]    byte_in;
  logic          hit;
  logic [3:0]    hit_row;
  logic          eval;
  logic          store;
  sprite_entry_t sel;

  // DMA holds the OAM bus, so every byte read during that time looks like 0xFF
  assign byte_in = dma_occupy_bus ? 8'hFF : oam_din;

  oam_scan_match u_match (
    .ly       (ly_q),
    .y        (y_q),
    .obj_size (obj_size_q),
    .match    (hit),
    .row      (hit_row)
  );

  assign eval  = ((state_q == RD_Y) && (n_q != 6'd0)) || (state_q == FLUSH);
  assign store = eval && hit && (count_q < LIST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      RD_Y:    state_d = RD_X;
      RD_X:    state_d = (n_q == LAST_ENTRY) ? FLUSH : RD_Y;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (scan_start) state_d = RD_Y;
  end

  always_comb begin
    oam_rd    = 1'b0;
    oam_a     = 8'h00;
    scan_busy = (state_q != IDLE);
    scan_done = (state_q == FLUSH);
    case (state_q)
      RD_Y: begin
        oam_rd = 1'b1;
        oam_a  = {n_q, 2'b00};
      end
      RD_X: begin
        oam_rd = 1'b1;
        oam_a  = {n_q, 2'b01};
      end
      default: begin
        oam_rd = 1'b0;
        oam_a  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      y_idx_q    <= '0;
      y_q        <= '0;
      ly_q       <= '0;
      obj_size_q <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < MAX_SPRITES; i++) list_q[i] <= '0;
    end else if (scan_start) begin
      n_q        <= '0;
      count_q    <= '0;
      ly_q       <= ly;
      obj_size_q <= obj_size;
    end else begin
      if (state_q == RD_X) begin
        y_q     <= byte_in;
        y_idx_q <= n_q;
        if (n_q != LAST_ENTRY) n_q <= n_q + 6'd1;
      end
      if (store) begin
        list_q[count_q].x       <= byte_in;
        list_q[count_q].oam_idx <= y_idx_q;
`ifdef OAM_SCAN_ROW_EN
        list_q[count_q].row     <= hit_row;
`else
        list_q[count_q].row     <= 4'd0;
`endif
        count_q <= count_q + 4'd1;
      end
    end
  end

  assign sprite_count = count_q;
  assign sel          = (list_idx < LIST_FULL) ? list_q[list_idx] : '0;
  assign list_x       = sel.x;
  assign list_oam_idx = sel.oam_idx;

`ifdef OAM_SCAN_ROW_EN
  assign list_row = sel.row;
`else
  logic unused_row;
  assign unused_row = ^{hit_row, sel.row};
  assign list_row   = 4'd0;
`endif

endmodule

// File: tb/tb_oam_scan.sv
// Directed self-checking bench for oam_scan with a simple OAM memory model.
module tb_oam_scan;

  logic       clk;
  logic       rst;
  logic       scan_start;
  logic [7:0] ly;
  logic       obj_size;
  logic       dma_occupy_bus;
  logic       oam_rd;
  logic [7:0] oam_a;
  logic [7:0] oam_din;
  logic       scan_busy;
  logic       scan_done;
  logic [3:0] sprite_count;
  logic [3:0] list_idx;
  logic [7:0] list_x;
  logic [5:0] list_oam_idx;
  logic [3:0] list_row;

  logic [7:0] oam [160];

  int checks;
  int errors;

  oam_scan dut (
    .clk            (clk),
    .rst            (rst),
    .scan_start     (scan_start),
    .ly             (ly),
    .obj_size       (obj_size),
    .dma_occupy_bus (dma_occupy_bus),
    .oam_rd         (oam_rd),
    .oam_a          (oam_a),
    .oam_din        (oam_din),
    .scan_busy      (scan_busy),
    .scan_done      (scan_done),
    .sprite_count   (sprite_count),
    .list_idx       (list_idx),
    .list_x         (list_x),
    .list_oam_idx   (list_oam_idx),
    .list_row       (list_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OAM returns data one cycle after the read strobe
  always @(posedge clk) begin
    if (oam_rd) oam_din <= oam[oam_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_y(input logic [7:0] yv);
    for (int i = 0; i < 40; i++) begin
      oam[4*i]   = yv;
      oam[4*i+1] = 8'h00;
      oam[4*i+2] = 8'h00;
      oam[4*i+3] = 8'h00;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  // called at the negedge following the start edge (cycle 1)
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (scan_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_entry(input int i, output logic [7:0] x, output logic [5:0] idx,
                            output logic [3:0] row);
    list_idx = 4'(i);
    #1;
    x   = list_x;
    idx = list_oam_idx;
    row = list_row;
  endtask

  initial begin
    int         lat;
    int         dones;
    logic       seen;
    logic [7:0] x;
    logic [5:0] idx;
    logic [3:0] row;
    logic [3:0] exp_row15;

    checks = 0;
    errors = 0;
`ifdef OAM_SCAN_ROW_EN
    exp_row15 = 4'd15;
`else
    exp_row15 = 4'd0;
`endif
    rst = 1'b1;
    scan_start = 1'b0;
    ly = 8'd0;
    obj_size = 1'b0;
    dma_occupy_bus = 1'b0;
    list_idx = 4'd0;
    oam_din = 8'h00;
    fill_y(8'h00);
    repeat (3) @(negedge clk);

    chk("rst_oam_rd", 32'(oam_rd), 0);
    chk("rst_oam_a", 32'(oam_a), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_count", 32'(sprite_count), 0);
    read_entry(0, x, idx, row);
    chk("rst_list_x", 32'(x), 0);
    chk("rst_list_idx", 32'(idx), 0);
    rst = 1'b0;

    // all Y=0, ly=0: no match, done 81 cycles after start
    start_pulse();
    chk("t1_busy_c1", 32'(scan_busy), 1);
    chk("t1_oam_a_c1", 32'(oam_a), 0);
    chk("t1_oam_rd_c1", 32'(oam_rd), 1);
    @(negedge clk);
    chk("t1_oam_a_c2", 32'(oam_a), 1);
    @(negedge clk);
    chk("t1_oam_a_c3", 32'(oam_a), 4);
    wait_done(lat);
    chk("t1_latency", 32'(lat + 2), 81);
    chk("t1_busy_c81", 32'(scan_busy), 1);
    chk("t1_oam_rd_flush", 32'(oam_rd), 0);
    chk("t1_count", 32'(sprite_count), 0);
    @(negedge clk);
    chk("t1_busy_c82", 32'(scan_busy), 0);
    chk("t1_done_c82", 32'(scan_done), 0);

    // 12 matching entries, list saturates at 10
    for (int i = 0; i < 12; i++) begin
      oam[4*i]   = 8'd16;
      oam[4*i+1] = 8'(8*i);
    end
    start_pulse();
    wait_done(lat);
    chk("t2_latency", 32'(lat), 81);
    chk("t2_count", 32'(sprite_count), 10);
    for (int i = 0; i < 10; i++) begin
      read_entry(i, x, idx, row);
      chk($sformatf("t2_x%0d", i), 32'(x), 32'(8*i));
      chk($sformatf("t2_idx%0d", i), 32'(idx), 32'(i));
      chk($sformatf("t2_row%0d", i), 32'(row), 0);
    end

    // restart at cycle 30: count clears at start, no early done
    start_pulse();
    chk("t3_count_clr", 32'(sprite_count), 0);
    seen = 1'b0;
    for (int k = 1; k < 29; k++) begin
      seen |= scan_done;
      @(negedge clk);
    end
    seen |= scan_done;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    chk("t3_count_restart", 32'(sprite_count), 0);
    wait_done(lat);
    chk("t3_no_early_done", 32'(seen), 0);
    chk("t3_latency", 32'(lat), 81);
    chk("t3_count", 32'(sprite_count), 10);
    read_entry(9, x, idx, row);
    chk("t3_x9", 32'(x), 72);
    chk("t3_idx9", 32'(idx), 9);

    // 8x16 object, ly at the last row
    fill_y(8'h00);
    oam[20] = 8'd16;
    oam[21] = 8'h33;
    ly = 8'd15;
    obj_size = 1'b1;
    start_pulse();
    wait_done(lat);
    chk("t4_latency", 32'(lat), 81);
    chk("t4_count", 32'(sprite_count), 1);
    read_entry(0, x, idx, row);
    chk("t4_x", 32'(x), 32'h33);
    chk("t4_idx", 32'(idx), 5);
    chk("t4_row", 32'(row), 32'(exp_row15));

    // same object in 8x8 mode misses
    obj_size = 1'b0;
    start_pulse();
    wait_done(lat);
    chk("t5_count", 32'(sprite_count), 0);

    // Y=0xFF with ly=239 matches at row 0
    oam[28] = 8'hFF;
    oam[29] = 8'h5A;
    ly = 8'd239;
    start_pulse();
    wait_done(lat);
    chk("t6_count", 32'(sprite_count), 1);
    read_entry(0, x, idx, row);
    chk("t6_x", 32'(x), 32'h5A);
    chk("t6_idx", 32'(idx), 7);
    chk("t6_row", 32'(row), 0);

    // DMA owns the bus: all bytes read as 0xFF, nothing matches at ly=0
    fill_y(8'd16);
    ly = 8'd0;
    dma_occupy_bus = 1'b1;
    start_pulse();
    wait_done(lat);
    chk("t7_count", 32'(sprite_count), 0);
    dma_occupy_bus = 1'b0;

    // reset at cycle 40 aborts without a done pulse
    start_pulse();
    repeat (38) @(negedge clk);
    chk("t8_busy_c39", 32'(scan_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_busy_rst", 32'(scan_busy), 0);
    chk("t8_count_rst", 32'(sprite_count), 0);
    chk("t8_done_rst", 32'(scan_done), 0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 120; k++) begin
      if (scan_done) dones++;
      @(negedge clk);
    end
    chk("t8_no_done", 32'(dones), 0);
    chk("t8_idle_busy", 32'(scan_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
